// File: rtl/pipe_issue_ctl.sv
// pipe_issue_ctl
// ----------------------------------------------------------------------------
// Issue scheduler and valid tracker for fixed-latency shift-register pipelines.
// A single start launches `count` iterations, one every II cycles. The block
// drives the common shift enable for the datapath shift registers and tracks
// one valid token per stage. While stalled it freezes. It pulses done once the
// last result has left the pipeline.
//
// Parameters
//   Depth       pipeline latency in stages (>= 2)
//   II          initiation interval in cycles (1..16)
//   CountWidth  width of the iteration count and index
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        launch request, sampled only while idle
//   count        number of iterations, latched when start is accepted
//   stall        freezes all state (no effect while idle)
//   busy         high whenever the controller is not idle
//   issue        a new iteration enters stage 0 this cycle
//   issue_idx    0-based index of the issuing iteration
//   shift_en     enable for all datapath shift registers
//   stage_valid  per-stage valid tokens, bit Depth-1 is the output stage
//   out_valid    the output-stage result is consumed this cycle
//   done         one-cycle completion pulse
// ----------------------------------------------------------------------------
module pipe_issue_ctl #(
    parameter int Depth      = 4,
    parameter int II         = 1,
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CountWidth-1:0] count,
    input  logic                  stall,
    output logic                  busy,
    output logic                  issue,
    output logic [CountWidth-1:0] issue_idx,
    output logic                  shift_en,
    output logic [Depth-1:0]      stage_valid,
    output logic                  out_valid,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    // The II counter only needs to reach 15, so a fixed 4-bit width avoids a
    // zero-width vector when II is 1.
    localparam logic [3:0]            IiLast = 4'(II - 1);
    localparam logic [CountWidth-1:0] One    = CountWidth'(1);

    state_t                state;
    state_t                state_next;
    logic [CountWidth-1:0] remaining;
    logic [CountWidth-1:0] remaining_next;
    logic [CountWidth-1:0] idx_next;
    logic [3:0]            ii_cnt;
    logic [3:0]            ii_next;
    logic                  done_next;

    // Next-state and output decode. issue, shift_en and out_valid depend
    // combinationally on stall so a stalled cycle neither issues nor shifts.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        idx_next       = issue_idx;
        ii_next        = ii_cnt;
        done_next      = 1'b0;
        issue          = 1'b0;
        busy           = (state != IDLE);
        shift_en       = busy & ~stall;

        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        remaining_next = count;
                        ii_next        = 4'd0;
                        idx_next       = '0;
                        state_next     = ISSUE;
                    end else begin
                        // An empty job completes immediately without ever
                        // becoming busy.
                        done_next = 1'b1;
                    end
                end
            end

            ISSUE: begin
                if (!stall) begin
                    issue   = (ii_cnt == 4'd0) && (remaining != '0);
                    ii_next = (ii_cnt == IiLast) ? 4'd0 : ii_cnt + 4'd1;
                    if (issue) begin
                        remaining_next = remaining - One;
                        idx_next       = issue_idx + One;
                        if (remaining == One) begin
                            state_next = DRAIN;
                        end
                    end
                end
            end

            DRAIN: begin
                // When only the output stage still holds a token, this shift
                // retires the last result, so done follows on the next cycle.
                if (shift_en && (stage_valid[Depth-2:0] == '0)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        out_valid = shift_en & stage_valid[Depth-1];
    end

    // State registers. Reset drops in-flight tokens and any pending done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            issue_idx   <= '0;
            ii_cnt      <= 4'd0;
            done        <= 1'b0;
            stage_valid <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            issue_idx <= idx_next;
            ii_cnt    <= ii_next;
            done      <= done_next;
            if (shift_en) begin
                stage_valid <= {stage_valid[Depth-2:0], issue};
            end
        end
    end

endmodule
